// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - shared pipeline-control types and defaults for hazard and forwarding logic
package pipe_ctrl_pkg;

    // Mul/div sequencer states
    typedef enum logic {
        MD_IDLE = 1'b0,
        MD_RUN  = 1'b1
    } md_state_e;

    // Default mul/div latencies in cycles
    localparam int MUL_CYCLES_DEF = 4;
    localparam int DIV_CYCLES_DEF = 32;

    // Forwarding mux selects, shared with the forwarding unit
    typedef enum logic [1:0] {
        FWD_NONE = 2'b00,
        FWD_WB   = 2'b01,
        FWD_MEM  = 2'b10
    } fwd_sel_e;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// rtl/hazard_ctrl_if.sv - pipeline-side signal bundle for the hazard controller
interface hazard_ctrl_if #(
    parameter int CNT_W = 16
);
    logic [4:0]       IF_ID_RS;
    logic [4:0]       IF_ID_RT;
    logic             IF_ID_UsesRT;
    logic             ID_IsMulDiv;
    logic             ID_IsDiv;
    logic             ID_ReadsHiLo;
    logic             ID_EX_MemRead;
    logic [4:0]       ID_EX_RT;
    logic             EX_BranchTaken;
    logic             MEM_Ready;

    logic             PC_Write;
    logic             IF_ID_Write;
    logic             ID_EX_Write;
    logic             EX_MEM_Write;
    logic             MEM_WB_Write;
    logic             IF_ID_Flush;
    logic             ID_EX_Flush;
    logic             MD_Start;
    logic             MD_Busy;
    logic [CNT_W-1:0] StallCnt;
    logic [CNT_W-1:0] FlushCnt;

    // Pipeline side: presents decode/hazard information, consumes enables
    modport master (
        output IF_ID_RS, IF_ID_RT, IF_ID_UsesRT, ID_IsMulDiv, ID_IsDiv, ID_ReadsHiLo,
               ID_EX_MemRead, ID_EX_RT, EX_BranchTaken, MEM_Ready,
        input  PC_Write, IF_ID_Write, ID_EX_Write, EX_MEM_Write, MEM_WB_Write,
               IF_ID_Flush, ID_EX_Flush, MD_Start, MD_Busy, StallCnt, FlushCnt
    );

    // Hazard controller side
    modport slave (
        input  IF_ID_RS, IF_ID_RT, IF_ID_UsesRT, ID_IsMulDiv, ID_IsDiv, ID_ReadsHiLo,
               ID_EX_MemRead, ID_EX_RT, EX_BranchTaken, MEM_Ready,
        output PC_Write, IF_ID_Write, ID_EX_Write, EX_MEM_Write, MEM_WB_Write,
               IF_ID_Flush, ID_EX_Flush, MD_Start, MD_Busy, StallCnt, FlushCnt
    );
endinterface

// File: rtl/muldiv_seq.sv
// rtl/muldiv_seq.sv - mul/div busy sequencer: launch loads a latency down-counter
module muldiv_seq
    import pipe_ctrl_pkg::*;
#(
    parameter int MUL_CYCLES = MUL_CYCLES_DEF,
    parameter int DIV_CYCLES = DIV_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic is_div,
    output logic busy
);
    localparam int CW = $clog2(max_int(MUL_CYCLES, DIV_CYCLES) + 1);

    md_state_e      state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;

    // Next state: runs independently of pipeline freeze; leaves RUN after the count==1 cycle
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            MD_IDLE: begin
                if (start) begin
                    state_d = MD_RUN;
                    cnt_d   = is_div ? CW'(DIV_CYCLES) : CW'(MUL_CYCLES);
                end
            end
            MD_RUN: begin
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = MD_IDLE;
                end
            end
            default: begin
                state_d = MD_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // State and counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= MD_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign busy = (state_q == MD_RUN);

endmodule

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - pipeline hazard priority logic, mul/div sequencing and perf counters
module hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MUL_CYCLES = MUL_CYCLES_DEF,
    parameter int DIV_CYCLES = DIV_CYCLES_DEF,
    parameter int CNT_W      = 16
) (
    input  logic         clk,
    input  logic         rst,
    hazard_ctrl_if.slave bus
);
    logic             load_use;
    logic             md_hazard;
    logic             stall_act;
    logic             flush_act;
    logic             md_start;
    logic             md_busy;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    // Hazard detection and priority: rst > freeze > branch > stall > normal
    always_comb begin
        load_use  = bus.ID_EX_MemRead && (bus.ID_EX_RT != 5'd0) &&
                    ((bus.ID_EX_RT == bus.IF_ID_RS) ||
                     (bus.IF_ID_UsesRT && (bus.ID_EX_RT == bus.IF_ID_RT)));
        md_hazard = md_busy && (bus.ID_IsMulDiv || bus.ID_ReadsHiLo);
        stall_act = 1'b0;
        flush_act = 1'b0;
        md_start  = 1'b0;

        bus.PC_Write     = 1'b1;
        bus.IF_ID_Write  = 1'b1;
        bus.ID_EX_Write  = 1'b1;
        bus.EX_MEM_Write = 1'b1;
        bus.MEM_WB_Write = 1'b1;
        bus.IF_ID_Flush  = 1'b0;
        bus.ID_EX_Flush  = 1'b0;

        if (rst) begin
            bus.PC_Write     = 1'b0;
            bus.IF_ID_Write  = 1'b0;
            bus.ID_EX_Write  = 1'b0;
            bus.EX_MEM_Write = 1'b0;
            bus.MEM_WB_Write = 1'b0;
            bus.IF_ID_Flush  = 1'b1;
            bus.ID_EX_Flush  = 1'b1;
        end else if (!bus.MEM_Ready) begin
            bus.PC_Write     = 1'b0;
            bus.IF_ID_Write  = 1'b0;
            bus.ID_EX_Write  = 1'b0;
            bus.EX_MEM_Write = 1'b0;
            bus.MEM_WB_Write = 1'b0;
        end else if (bus.EX_BranchTaken) begin
            // ID instruction is killed, so it never launches the mul/div unit
            bus.IF_ID_Flush  = 1'b1;
            bus.ID_EX_Flush  = 1'b1;
            flush_act        = 1'b1;
        end else if (load_use || md_hazard) begin
            bus.PC_Write     = 1'b0;
            bus.IF_ID_Write  = 1'b0;
            bus.ID_EX_Flush  = 1'b1;
            stall_act        = 1'b1;
        end else begin
            md_start         = bus.ID_IsMulDiv;
        end

        bus.MD_Start = md_start;
    end

    // Saturating counters: one increment per qualifying cycle, never wrap
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (stall_act && !(&stall_cnt_q)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
        if (flush_act && !(&flush_cnt_q)) begin
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end
    end

    // Counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    muldiv_seq #(
        .MUL_CYCLES (MUL_CYCLES),
        .DIV_CYCLES (DIV_CYCLES)
    ) u_muldiv_seq (
        .clk    (clk),
        .rst    (rst),
        .start  (md_start),
        .is_div (bus.ID_IsDiv),
        .busy   (md_busy)
    );

    assign bus.MD_Busy  = md_busy;
    assign bus.StallCnt = stall_cnt_q;
    assign bus.FlushCnt = flush_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - directed self-checking bench for hazard_ctrl
module tb_hazard_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks   = 0;
    int   failures = 0;

    hazard_ctrl_if #(.CNT_W(16)) hif ();

    hazard_ctrl #(
        .MUL_CYCLES (4),
        .DIV_CYCLES (32),
        .CNT_W      (16)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (hif.slave)
    );

    always #5 clk = ~clk;

    logic [4:0] wr;
    logic [1:0] fl;
    assign wr = {hif.PC_Write, hif.IF_ID_Write, hif.ID_EX_Write, hif.EX_MEM_Write, hif.MEM_WB_Write};
    assign fl = {hif.IF_ID_Flush, hif.ID_EX_Flush};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        hif.IF_ID_RS       = 5'd0;
        hif.IF_ID_RT       = 5'd0;
        hif.IF_ID_UsesRT   = 1'b0;
        hif.ID_IsMulDiv    = 1'b0;
        hif.ID_IsDiv       = 1'b0;
        hif.ID_ReadsHiLo   = 1'b0;
        hif.ID_EX_MemRead  = 1'b0;
        hif.ID_EX_RT       = 5'd0;
        hif.EX_BranchTaken = 1'b0;
        hif.MEM_Ready      = 1'b1;
    endtask

    initial begin
        clear_inputs();
        rst = 1'b1;
        #1;
        // Reset outputs
        chk("rst_writes", wr, 5'b00000);
        chk("rst_flush", fl, 2'b11);
        chk("rst_start", hif.MD_Start, 1'b0);
        hif.ID_IsMulDiv = 1'b1;
        #1;
        chk("rst_start_muldiv", hif.MD_Start, 1'b0);
        hif.ID_IsMulDiv = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        #1;
        chk("post_rst_stallcnt", hif.StallCnt, 16'h0000);
        chk("post_rst_flushcnt", hif.FlushCnt, 16'h0000);
        chk("post_rst_busy", hif.MD_Busy, 1'b0);
        chk("normal_writes", wr, 5'b11111);
        chk("normal_flush", fl, 2'b00);

        // Load-use on RS
        hif.ID_EX_MemRead = 1'b1;
        hif.ID_EX_RT      = 5'd5;
        hif.IF_ID_RS      = 5'd5;
        #1;
        chk("lu_rs_writes", wr, 5'b00111);
        chk("lu_rs_flush", fl, 2'b01);
        tick();
        hif.ID_EX_MemRead = 1'b0;
        #1;
        chk("lu_rs_after_writes", wr, 5'b11111);
        chk("lu_rs_stallcnt", hif.StallCnt, 16'h0001);

        // Load to $0 never stalls
        hif.ID_EX_MemRead = 1'b1;
        hif.ID_EX_RT      = 5'd0;
        hif.IF_ID_RS      = 5'd0;
        #1;
        chk("lu_r0_writes", wr, 5'b11111);
        // RT match only counts when RT is a source
        hif.ID_EX_RT = 5'd7;
        hif.IF_ID_RS = 5'd3;
        hif.IF_ID_RT = 5'd7;
        #1;
        chk("lu_rt_unused_writes", wr, 5'b11111);
        hif.IF_ID_UsesRT = 1'b1;
        #1;
        chk("lu_rt_used_writes", wr, 5'b00111);
        tick();
        clear_inputs();
        #1;
        chk("lu_rt_stallcnt", hif.StallCnt, 16'h0002);

        // mult accepted at T, mfhi behind it
        hif.ID_IsMulDiv = 1'b1;
        #1;
        chk("mul_start", hif.MD_Start, 1'b1);
        chk("mul_start_writes", wr, 5'b11111);
        tick();
        hif.ID_IsMulDiv  = 1'b0;
        hif.ID_ReadsHiLo = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            #1;
            chk("mul_busy", hif.MD_Busy, 1'b1);
            chk("mul_stall_writes", wr, 5'b00111);
            chk("mul_no_start", hif.MD_Start, 1'b0);
            tick();
        end
        chk("mul_done_busy", hif.MD_Busy, 1'b0);
        chk("mul_done_writes", wr, 5'b11111);
        chk("mul_stallcnt", hif.StallCnt, 16'h0006);
        tick();
        clear_inputs();

        // div accepted at T, mfhi behind it for 32 cycles
        hif.ID_IsMulDiv = 1'b1;
        hif.ID_IsDiv    = 1'b1;
        #1;
        chk("div_start", hif.MD_Start, 1'b1);
        tick();
        clear_inputs();
        hif.ID_ReadsHiLo = 1'b1;
        for (int i = 1; i <= 32; i++) begin
            #1;
            chk("div_busy", hif.MD_Busy, 1'b1);
            chk("div_stall_writes", wr, 5'b00111);
            tick();
        end
        chk("div_done_busy", hif.MD_Busy, 1'b0);
        chk("div_done_writes", wr, 5'b11111);
        chk("div_stallcnt", hif.StallCnt, 16'd38);
        clear_inputs();

        // Branch together with load-use and a mul in ID
        hif.EX_BranchTaken = 1'b1;
        hif.ID_EX_MemRead  = 1'b1;
        hif.ID_EX_RT       = 5'd5;
        hif.IF_ID_RS       = 5'd5;
        hif.ID_IsMulDiv    = 1'b1;
        #1;
        chk("br_lu_writes", wr, 5'b11111);
        chk("br_lu_flush", fl, 2'b11);
        chk("br_lu_start", hif.MD_Start, 1'b0);
        tick();
        clear_inputs();
        #1;
        chk("br_lu_stallcnt", hif.StallCnt, 16'd38);
        chk("br_lu_flushcnt", hif.FlushCnt, 16'd1);
        chk("br_lu_no_launch", hif.MD_Busy, 1'b0);

        // Freeze for 3 cycles while a mul has 2 cycles left, branch pending
        hif.ID_IsMulDiv = 1'b1;
        #1;
        chk("frz_mul_start", hif.MD_Start, 1'b1);
        tick();
        clear_inputs();
        tick();
        tick();
        hif.MEM_Ready      = 1'b0;
        hif.EX_BranchTaken = 1'b1;
        #1;
        chk("frz1_writes", wr, 5'b00000);
        chk("frz1_flush", fl, 2'b00);
        chk("frz1_busy", hif.MD_Busy, 1'b1);
        tick();
        chk("frz2_writes", wr, 5'b00000);
        chk("frz2_busy", hif.MD_Busy, 1'b1);
        tick();
        chk("frz3_writes", wr, 5'b00000);
        chk("frz3_flush", fl, 2'b00);
        chk("frz3_busy", hif.MD_Busy, 1'b0);
        chk("frz3_flushcnt", hif.FlushCnt, 16'd1);
        tick();
        hif.MEM_Ready = 1'b1;
        #1;
        chk("frz_end_flush", fl, 2'b11);
        chk("frz_end_pcwrite", hif.PC_Write, 1'b1);
        tick();
        clear_inputs();
        #1;
        chk("frz_flushcnt", hif.FlushCnt, 16'd2);
        chk("frz_stallcnt", hif.StallCnt, 16'd38);

        // Reset in the middle of a div, with count at 17
        hif.ID_IsMulDiv = 1'b1;
        hif.ID_IsDiv    = 1'b1;
        tick();
        clear_inputs();
        repeat (15) tick();
        chk("mid_div_busy", hif.MD_Busy, 1'b1);
        rst = 1'b1;
        #1;
        chk("mid_div_rst_writes", wr, 5'b00000);
        chk("mid_div_rst_flush", fl, 2'b11);
        tick();
        rst = 1'b0;
        #1;
        chk("mid_div_rst_busy", hif.MD_Busy, 1'b0);
        chk("mid_div_rst_stallcnt", hif.StallCnt, 16'h0000);
        chk("mid_div_rst_flushcnt", hif.FlushCnt, 16'h0000);

        // Stall counter saturation under a held load-use hazard
        hif.ID_EX_MemRead = 1'b1;
        hif.ID_EX_RT      = 5'd9;
        hif.IF_ID_RS      = 5'd9;
        repeat (65534) tick();
        chk("sat_near", hif.StallCnt, 16'hFFFE);
        tick();
        chk("sat_full", hif.StallCnt, 16'hFFFF);
        chk("sat_stall_writes", wr, 5'b00111);
        tick();
        chk("sat_hold", hif.StallCnt, 16'hFFFF);
        clear_inputs();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
